// File: rtl/arbiter_rr_sdp.sv
// arbiter_rr_sdp: round-robin arbiter sharing one variable-latency single-port memory among NUM_PORTS requesters.
// Optional feature: define ARBITER_TIMEOUT_EN to abort a transaction with an err pulse after TIMEOUT busy cycles.
module arbiter_rr_sdp #(
    parameter int WIDTH     = 32,
    parameter int SIZE      = 16,
    parameter int IDX_SIZE  = 4,
    parameter int NUM_PORTS = 4,
    parameter int TIMEOUT   = 64
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_PORTS*IDX_SIZE-1:0] addr,
    input  logic [NUM_PORTS*WIDTH-1:0]    in,
    input  logic [NUM_PORTS-1:0]          read_en,
    input  logic [NUM_PORTS-1:0]          write_en,
    output logic [NUM_PORTS*WIDTH-1:0]    out,
    output logic [NUM_PORTS-1:0]          read_done,
    output logic [NUM_PORTS-1:0]          write_done,
    output logic [NUM_PORTS-1:0]          err,
    output logic [IDX_SIZE-1:0]           mem_addr,
    output logic [WIDTH-1:0]              mem_in,
    output logic                          mem_read_en,
    output logic                          mem_write_en,
    input  logic [WIDTH-1:0]              mem_out,
    input  logic                          mem_read_done,
    input  logic                          mem_write_done
);
    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t               state, state_n;
    logic [NUM_PORTS-1:0] req;
    logic [PW-1:0]        ptr, sel;
    logic                 found, op, match, tmo, busy;
    logic [IDX_SIZE-1:0]  a_q;
    logic [WIDTH-1:0]     d_q;

    assign req   = read_en | write_en;
    assign found = |req;
    assign busy  = state == BUSY;
    assign match = op ? mem_write_done : mem_read_done;

    assign mem_addr     = busy ? a_q : '0;
    assign mem_in       = busy ? d_q : '0;
    assign mem_write_en = busy && op;
    assign mem_read_en  = busy && !op;

    // Nearest requester after ptr wins: scan farthest-first so the closest overwrites.
    always_comb begin
        sel = '0;
        for (int k = NUM_PORTS; k >= 1; k--)
            if (req[(int'(ptr) + k) % NUM_PORTS]) sel = PW'((int'(ptr) + k) % NUM_PORTS);
    end

    // Next state: grant from IDLE, leave BUSY on matching done or abort, DONE lasts one cycle.
    always_comb begin
        state_n = state == IDLE ? (found ? BUSY : IDLE) : busy ? ((match || tmo) ? DONE : BUSY) : IDLE;
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

    // Grant capture, read-data hold registers and one-cycle done pulses; ptr doubles as the granted port.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr        <= PW'(NUM_PORTS - 1);
            op         <= 1'b0;
            a_q        <= '0;
            d_q        <= '0;
            out        <= '0;
            read_done  <= '0;
            write_done <= '0;
        end else begin
            read_done  <= '0;
            write_done <= '0;
            if (state == IDLE && found) begin
                ptr <= sel;
                op  <= write_en[sel];
                a_q <= addr[int'(sel)*IDX_SIZE +: IDX_SIZE];
                d_q <= in[int'(sel)*WIDTH +: WIDTH];
            end
            if (busy && match) begin
                if (op) write_done[ptr] <= 1'b1;
                else begin
                    read_done[ptr]                <= 1'b1;
                    out[int'(ptr)*WIDTH +: WIDTH] <= mem_out;
                end
            end
        end
    end

`ifdef ARBITER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt;

    assign tmo = busy && !match && cnt == CW'(TIMEOUT - 1);

    // Busy-cycle counter, held at zero while idle so it starts clean on every grant.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
            err <= '0;
        end else begin
            err <= '0;
            cnt <= state == IDLE ? '0 : cnt + 1'b1;
            if (tmo) err[ptr] <= 1'b1;
        end
    end
`else
    assign tmo = 1'b0;
    assign err = '0;
`endif
endmodule

// File: tb/tb_arbiter_rr_sdp.sv
// tb_arbiter_rr_sdp: scoreboard bench for arbiter_rr_sdp with a variable-latency memory model.
// Define ARBITER_TIMEOUT_EN to also exercise the timeout abort path (TIMEOUT=8).
module tb_arbiter_rr_sdp;
    localparam int W = 32;
    localparam int IW = 4;
    localparam int NP = 4;

    typedef struct {
        int          port;
        int          kind;
        logic [31:0] data;
    } exp_t;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [NP*IW-1:0] addr = '0;
    logic [NP*W-1:0]  in = '0;
    logic [NP-1:0]    read_en = '0, write_en = '0;
    logic [NP*W-1:0]  out;
    logic [NP-1:0]    read_done, write_done, err;
    logic [IW-1:0]    mem_addr;
    logic [W-1:0]     mem_in, mem_out;
    logic             mem_read_en, mem_write_en, mem_read_done, mem_write_done;

    logic [W-1:0] mem [16];
    int  lat = 0;
    int  cnt = 0;
    bit  hang = 0;
    bit  stray = 0;

    exp_t sb[$];
    exp_t me;
    logic [NP-1:0] er, ew, ee;
    int n_cmp = 0;
    int n_bad = 0;

    arbiter_rr_sdp #(.WIDTH(W), .SIZE(16), .IDX_SIZE(IW), .NUM_PORTS(NP), .TIMEOUT(8)) dut (
        .clk(clk), .reset(reset), .addr(addr), .in(in), .read_en(read_en), .write_en(write_en),
        .out(out), .read_done(read_done), .write_done(write_done), .err(err),
        .mem_addr(mem_addr), .mem_in(mem_in), .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
        .mem_out(mem_out), .mem_read_done(mem_read_done), .mem_write_done(mem_write_done)
    );

    always #5 clk = ~clk;

    assign mem_out        = mem[mem_addr];
    assign mem_read_done  = stray || (mem_read_en && cnt == lat && !hang);
    assign mem_write_done = mem_write_en && cnt == lat && !hang;

    always @(posedge clk) begin
        cnt <= ((mem_read_en && !mem_read_done) || (mem_write_en && !mem_write_done)) ? cnt + 1 : 0;
        if (mem_write_en && mem_write_done) mem[mem_addr] <= mem_in;
    end

    always @(negedge clk) begin
        if (reset && (|read_done || |write_done || |err)) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_done: rd=%b wr=%b err=%b, required no pulse", read_done, write_done, err);
            end else begin
                me = sb.pop_front();
                er = me.kind == 0 ? NP'(1) << me.port : '0;
                ew = me.kind == 1 ? NP'(1) << me.port : '0;
                ee = me.kind == 2 ? NP'(1) << me.port : '0;
                if ({read_done, write_done, err} !== {er, ew, ee}) begin
                    n_bad++;
                    $display("FAIL done_pulse: rd=%b wr=%b err=%b, required rd=%b wr=%b err=%b",
                             read_done, write_done, err, er, ew, ee);
                end else if (me.kind == 0 && out[me.port*W +: W] !== me.data) begin
                    n_bad++;
                    $display("FAIL read_data port %0d: got %h, required %h", me.port, out[me.port*W +: W], me.data);
                end
            end
        end
    end

    task automatic wait_sb(input int budget);
        int c = 0;
        while (sb.size() != 0 && c < budget) begin
            @(negedge clk);
            #1;
            c++;
        end
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_sb: %0d pending after %0d cycles, required 0", sb.size(), budget);
            sb.delete();
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({mem_read_en, mem_write_en, mem_addr, mem_in} !== '0) begin
            n_bad++;
            $display("FAIL reset_mem: got %h, required 0", {mem_read_en, mem_write_en, mem_addr, mem_in});
        end
        n_cmp++;
        if ({read_done, write_done, err} !== '0) begin
            n_bad++;
            $display("FAIL reset_done: got %b, required 0", {read_done, write_done, err});
        end
        n_cmp++;
        if (out !== '0) begin
            n_bad++;
            $display("FAIL reset_out: got %h, required 0", out);
        end
        reset = 1'b1;
    endtask

    task automatic test_single_write();
        int c = 0;
        @(negedge clk);
        addr[2*IW +: IW] = 4'd5;
        in[2*W +: W] = 32'hDEADBEEF;
        write_en[2] = 1'b1;
        lat = 1;
        sb.push_back('{2, 1, 32'h0});
        @(negedge clk);
        write_en = '0;
        while (mem_write_en && c < 10) begin
            n_cmp++;
            if (mem_addr !== 4'd5 || mem_in !== 32'hDEADBEEF || mem_read_en !== 1'b0) begin
                n_bad++;
                $display("FAIL write_bus: addr=%h in=%h rd_en=%b, required 5 deadbeef 0", mem_addr, mem_in, mem_read_en);
            end
            c++;
            @(negedge clk);
        end
        n_cmp++;
        if (c !== 2) begin
            n_bad++;
            $display("FAIL write_en_cycles: got %0d, required 2", c);
        end
        wait_sb(10);
        n_cmp++;
        if (mem[5] !== 32'hDEADBEEF) begin
            n_bad++;
            $display("FAIL write_mem: got %h, required deadbeef", mem[5]);
        end
    endtask

    task automatic test_read();
        @(negedge clk);
        addr[1*IW +: IW] = 4'd3;
        read_en[1] = 1'b1;
        lat = 2;
        sb.push_back('{1, 0, 32'h1234});
        @(negedge clk);
        read_en = '0;
        wait_sb(20);
        repeat (3) @(negedge clk);
        n_cmp++;
        if (out[1*W +: W] !== 32'h1234) begin
            n_bad++;
            $display("FAIL read_hold: got %h, required 1234", out[1*W +: W]);
        end
    endtask

    task automatic test_round_robin();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        lat = 0;
        for (int i = 0; i < NP; i++) addr[i*IW +: IW] = IW'(8 + i);
        for (int i = 0; i < 5; i++) sb.push_back('{i % NP, 0, 32'h100 + 32'(i % NP)});
        read_en = '1;
        wait_sb(40);
        read_en = '0;
    endtask

    task automatic test_both_en();
        @(negedge clk);
        addr[0 +: IW] = 4'd7;
        in[0 +: W] = 32'hA5A5A5A5;
        read_en[0] = 1'b1;
        write_en[0] = 1'b1;
        stray = 1'b1;
        lat = 2;
        sb.push_back('{0, 1, 32'h0});
        @(negedge clk);
        read_en = '0;
        write_en = '0;
        wait_sb(20);
        stray = 1'b0;
        n_cmp++;
        if (mem[7] !== 32'hA5A5A5A5) begin
            n_bad++;
            $display("FAIL both_write_mem: got %h, required a5a5a5a5", mem[7]);
        end
    endtask

    task automatic test_reset_busy();
        int c = 0;
        @(negedge clk);
        hang = 1'b1;
        addr[2*IW +: IW] = 4'd3;
        read_en[2] = 1'b1;
        @(negedge clk);
        read_en = '0;
        while (!mem_read_en && c < 10) begin
            @(negedge clk);
            c++;
        end
        n_cmp++;
        if (mem_read_en !== 1'b1) begin
            n_bad++;
            $display("FAIL busy_before_reset: mem_read_en=%b, required 1", mem_read_en);
        end
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({mem_read_en, mem_write_en, mem_addr, mem_in, read_done, write_done, err} !== '0) begin
            n_bad++;
            $display("FAIL reset_busy_outputs: got %h, required 0",
                     {mem_read_en, mem_write_en, mem_addr, mem_in, read_done, write_done, err});
        end
        n_cmp++;
        if (out !== '0) begin
            n_bad++;
            $display("FAIL reset_busy_out: got %h, required 0", out);
        end
        @(negedge clk);
        reset = 1'b1;
        hang = 1'b0;
        repeat (3) @(negedge clk);
        addr[0 +: IW] = 4'd8;
        addr[3*IW +: IW] = 4'd11;
        sb.push_back('{0, 0, 32'h100});
        sb.push_back('{3, 0, 32'h103});
        read_en = 4'b1001;
        wait_sb(30);
        read_en = '0;
    endtask

    task automatic test_back_to_back();
        int c = 0;
        @(negedge clk);
        lat = 0;
        addr[1*IW +: IW] = 4'd9;
        addr[2*IW +: IW] = 4'd10;
        for (int i = 0; i < 4; i++) sb.push_back('{1 + i % 2, 0, 32'h101 + 32'(i % 2)});
        read_en = 4'b0110;
        while (sb.size() != 0 && c < 40) begin
            @(negedge clk);
            #1;
            c++;
        end
        read_en = '0;
        n_cmp++;
        if (c !== 11) begin
            n_bad++;
            $display("FAIL back_to_back_cycles: got %0d, required 11", c);
        end
        sb.delete();
    endtask

`ifdef ARBITER_TIMEOUT_EN
    task automatic test_timeout();
        int c = 0;
        logic [W-1:0] keep;
        @(negedge clk);
        keep = out[1*W +: W];
        hang = 1'b1;
        addr[1*IW +: IW] = 4'd2;
        addr[2*IW +: IW] = 4'd9;
        read_en[1] = 1'b1;
        sb.push_back('{1, 2, 32'h0});
        sb.push_back('{2, 0, 32'h101});
        @(negedge clk);
        read_en[1] = 1'b0;
        read_en[2] = 1'b1;
        while (mem_read_en && c < 30) begin
            c++;
            @(negedge clk);
        end
        hang = 1'b0;
        n_cmp++;
        if (c !== 8) begin
            n_bad++;
            $display("FAIL timeout_cycles: got %0d, required 8", c);
        end
        n_cmp++;
        if (out[1*W +: W] !== keep) begin
            n_bad++;
            $display("FAIL timeout_out_hold: got %h, required %h", out[1*W +: W], keep);
        end
        wait_sb(30);
        read_en = '0;
    endtask
`endif

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        mem[3] = 32'h1234;
        for (int i = 0; i < NP; i++) mem[8 + i] = 32'h100 + 32'(i);
        test_reset();
        test_single_write();
        test_read();
        test_round_robin();
        test_both_en();
        test_reset_busy();
        test_back_to_back();
`ifdef ARBITER_TIMEOUT_EN
        test_timeout();
`endif
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
